// File: rtl/on_chip_mem_write_if.sv
// Write-side port of the on-chip sample memory.
interface on_chip_mem_write_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 12
);
    logic [ADDR_W-1:0] address_out;
    logic [DATA_W-1:0] writedata;
    logic              clk_en;
    logic              cs;
    logic              write;

    // Controller drives the port.
    modport master (
        output address_out,
        output writedata,
        output clk_en,
        output cs,
        output write
    );

    // Memory receives the port.
    modport slave (
        input address_out,
        input writedata,
        input clk_en,
        input cs,
        input write
    );
endinterface

// File: rtl/on_chip_mem_write.sv
// Triggered ADC burst capture into the on-chip sample memory.
module on_chip_mem_write #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
    input  logic              trig_rising,
    input  logic [DATA_W-1:0] threshold,
    input  logic [ADDR_W-1:0] capture_len,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    on_chip_mem_write_if.master mem,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   samples_written
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  len_q;
    logic [DATA_W-1:0] prev_sample;
    logic              prev_valid;
    logic              trig_hit;
    logic [CNT_W-1:0]  sw_inc;

    // Memory clock is always enabled.
    assign mem.clk_en = 1'b1;

    // Edge trigger on the threshold crossing, or forced.
    always_comb begin
        trig_hit = 1'b0;
        if (force_trig) begin
            trig_hit = 1'b1;
        end else if (prev_valid) begin
            if (trig_rising) begin
                trig_hit = (prev_sample < threshold) && (sample >= threshold);
            end else begin
                trig_hit = (prev_sample > threshold) && (sample <= threshold);
            end
        end
    end

    assign sw_inc = samples_written + CNT_W'(1);

    // Capture FSM with registered memory port and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            len_q           <= FULL_LEN;
            prev_sample     <= '0;
            prev_valid      <= 1'b0;
            samples_written <= '0;
            mem.address_out <= '0;
            mem.writedata   <= '0;
            mem.cs          <= 1'b0;
            mem.write       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            mem.cs    <= 1'b0;
            mem.write <= 1'b0;
            if (abort) begin
                state      <= S_IDLE;
                prev_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            state           <= S_ARMED;
                            len_q           <= (capture_len == '0) ? FULL_LEN
                                                                   : {1'b0, capture_len};
                            samples_written <= '0;
                            prev_valid      <= 1'b0;
                            busy            <= 1'b1;
                            done            <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (sample_valid) begin
                            prev_sample <= sample;
                            prev_valid  <= 1'b1;
                            if (trig_hit) begin
                                mem.address_out <= '0;
                                mem.writedata   <= sample;
                                mem.cs          <= 1'b1;
                                mem.write       <= 1'b1;
                                samples_written <= CNT_W'(1);
                                if (len_q == CNT_W'(1)) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state <= S_CAPTURE;
                                end
                            end
                        end
                    end
                    S_CAPTURE: begin
                        if (sample_valid) begin
                            mem.address_out <= samples_written[ADDR_W-1:0];
                            mem.writedata   <= sample;
                            mem.cs          <= 1'b1;
                            mem.write       <= 1'b1;
                            samples_written <= sw_inc;
                            if (sw_inc == len_q) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
